// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter:
// FSM encoding, field widths, limits and the header packing helper.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int MAX_LEN = 63;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_HEADER = 3'd2;
  localparam logic [2:0] ST_PAYLD  = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_ERRCHK = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    LOAD    = ST_LOAD,
    HEADER  = ST_HEADER,
    PAYLOAD = ST_PAYLD,
    PARITY  = ST_PARITY,
    ERRCHK  = ST_ERRCHK
  } state_t;

  function automatic logic [7:0] pack_hdr(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: 64x8 RAM, one write port, one registered read port.
// Ports: clock, we/waddr/wdata write side, raddr in, rdata out (1-cycle latency, write-first).
module router_tx_buf
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             we,
  input  logic [LEN_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [LEN_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [0:MAX_LEN];

  // Write-first: a same-address read returns the byte being written,
  // so a 1-byte packet can be prefetched on its own write edge.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (we && waddr == raddr) rdata <= wdata;
    else                      rdata <= mem[raddr];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Router ingress packet source: buffers a host payload, then sends header, payload, parity.
// Ports: clock/reset, start_* host request, pl_* payload load, busy/err from router,
//   pkt_valid/data_out to router, done/done_err/start_rej status.
// Optional: PARITY_INJECT_EN adds inject_err to corrupt the parity byte of one packet.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int ERR_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [7:0]        pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [7:0]        data_out,
  output logic              done,
  output logic              done_err,
  output logic              start_rej
`ifdef PARITY_INJECT_EN
  ,input logic              inject_err
`endif
);

  localparam logic [3:0] EW_LAST = 4'(ERR_WAIT - 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wp_q, wp_d;
  logic [LEN_W-1:0] rp_q, rp_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0] par_q, par_d;
  logic [7:0] data_q, data_d;
  logic pv_q, pv_d;
  logic done_q, done_d;
  logic derr_q, derr_d;
  logic rej_q, rej_d;
  logic acc_q, acc_d;
  logic inj_q, inj_d;
  logic [3:0] ew_q, ew_d;
  logic xfer;
  logic we;
  logic [7:0] rdata;

  assign we = (state_q == LOAD) && pl_valid;

  router_tx_buf u_buf (
    .clock (clock),
    .we    (we),
    .waddr (wp_q),
    .wdata (pl_data),
    .raddr (rp_d),
    .rdata (rdata)
  );

  // rdata always mirrors buf[rp_q]; the byte after the one on
  // data_out is therefore ready on every transfer edge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    data_d  = data_q;
    pv_d    = pv_q;
    derr_d  = derr_q;
    acc_d   = acc_q;
    inj_d   = inj_q;
    ew_d    = ew_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    xfer    = (pv_q || state_q == PARITY) && !busy;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          if (start_addr == INVALID_ADDR || start_len == '0) begin
            rej_d = 1'b1;
          end else begin
            addr_d  = start_addr;
            len_d   = start_len;
            wp_d    = '0;
            state_d = LOAD;
`ifdef PARITY_INJECT_EN
            inj_d   = inject_err;
`else
            inj_d   = 1'b0;
`endif
          end
        end
      end
      LOAD: begin
        if (pl_valid) begin
          wp_d = wp_q + 1'b1;
          if (wp_q == len_q - 1'b1) begin
            state_d = HEADER;
            pv_d    = 1'b1;
            data_d  = pack_hdr(len_q, addr_q);
            rp_d    = '0;
          end
        end
      end
      HEADER: begin
        if (xfer) begin
          state_d = PAYLOAD;
          data_d  = rdata;
          rp_d    = rp_q + 1'b1;
          cnt_d   = '0;
          par_d   = data_q;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          par_d = par_q ^ data_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = PARITY;
            pv_d    = 1'b0;
            data_d  = par_q ^ data_q ^ {8{inj_q}};
          end else begin
            data_d  = rdata;
            rp_d    = rp_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (xfer) begin
          state_d = ERRCHK;
          ew_d    = '0;
          acc_d   = 1'b0;
        end
      end
      ERRCHK: begin
        acc_d = acc_q | err;
        ew_d  = ew_q + 1'b1;
        if (ew_q == EW_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          derr_d  = acc_q | err;
          data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      data_q  <= '0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      derr_q  <= 1'b0;
      rej_q   <= 1'b0;
      acc_q   <= 1'b0;
      inj_q   <= 1'b0;
      ew_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      derr_q  <= derr_d;
      rej_q   <= rej_d;
      acc_q   <= acc_d;
      inj_q   <= inj_d;
      ew_q    <= ew_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign pl_ready    = (state_q == LOAD);
  assign pkt_valid   = pv_q;
  assign data_out    = data_q;
  assign done        = done_q;
  assign done_err    = derr_q;
  assign start_rej   = rej_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed packets plus randomized
// traffic checked against a byte-stream reference model.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [1:0] start_addr = '0;
  logic [5:0] start_len = '0;
  logic [7:0] pl_data = '0;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       done;
  logic       done_err;
  logic       start_rej;
`ifdef PARITY_INJECT_EN
  logic       inject_err = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] tx_pl[$];

  always #5 clock = ~clock;

  router_pkt_tx dut (
    .clock       (clock),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_addr  (start_addr),
    .start_len   (start_len),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .busy        (busy),
    .err         (err),
    .pkt_valid   (pkt_valid),
    .data_out    (data_out),
    .done        (done),
    .done_err    (done_err),
    .start_rej   (start_rej)
`ifdef PARITY_INJECT_EN
    ,.inject_err (inject_err)
`endif
  );

  // Sends tx_pl as one packet and checks the serialised stream.
  // busy_mode: 0 none, 1 random, 2 two-cycle stall on payload byte 1.
  task automatic run_pkt(input logic [1:0] a, input int len,
                         input int busy_mode, input bit use_err,
                         input bit inj, input int rst_at,
                         input bit gaps);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] hdr;
    logic [7:0] par;
    int idx;
    int since;
    int busy_left;
    int cyc;
    bit par_seen;
    bit fin;
    bit held;
    idx = 0; since = 0; busy_left = 0;
    par_seen = 0; fin = 0; held = 0;
    hdr = {len[5:0], a};
    par = hdr;
    exp_q.push_back(hdr);
    foreach (tx_pl[i]) begin
      exp_q.push_back(tx_pl[i]);
      par ^= tx_pl[i];
    end
    if (inj) par = ~par;
    exp_q.push_back(par);

    cyc = 0;
    while (start_ready !== 1'b1 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    n_chk++;
    if (start_ready !== 1'b1)
      $display("FAIL start_ready before start: got %b want 1", start_ready);
    else n_pass++;
    start_valid = 1'b1;
    start_addr  = a;
    start_len   = len[5:0];
`ifdef PARITY_INJECT_EN
    inject_err  = inj;
`endif
    @(negedge clock);
    start_valid = 1'b0;

    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (par_seen) since++;
      if (done === 1'b1) begin
        fin = 1;
        n_chk++;
        if (done_err !== use_err)
          $display("FAIL done_err: got %b want %b", done_err, use_err);
        else n_pass++;
        n_chk++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00)
          $display("FAIL idle outputs at done: got pv=%b d=%h want 0/00",
                   pkt_valid, data_out);
        else n_pass++;
      end else begin
        if (rst_at > 0 && pkt_valid === 1'b1 && got_q.size() == rst_at) begin
          reset = 1'b1;
          #1;
          n_chk++;
          if (pkt_valid !== 1'b0 || data_out !== 8'h00)
            $display("FAIL async reset: got pv=%b d=%h want 0/00",
                     pkt_valid, data_out);
          else n_pass++;
          @(negedge clock);
          pl_valid = 1'b0; busy = 1'b0; err = 1'b0;
          reset = 1'b0;
          @(negedge clock);
          n_chk++;
          if (start_ready !== 1'b1 || pl_ready !== 1'b0 || pkt_valid !== 1'b0)
            $display("FAIL after reset: got sr=%b pr=%b pv=%b want 1/0/0",
                     start_ready, pl_ready, pkt_valid);
          else n_pass++;
          return;
        end
        pl_valid = 1'b0;
        if (pl_ready === 1'b1 && idx < len &&
            (!gaps || $urandom_range(3) != 0)) begin
          pl_valid = 1'b1;
          pl_data  = tx_pl[idx];
          idx++;
        end
        err = (use_err && par_seen && since == 2) ||
              (gaps && idx < len && $urandom_range(1) == 1);
        busy = 1'b0;
        if (busy_mode == 1) begin
          busy = ($urandom_range(2) == 0);
        end else if (busy_mode == 2) begin
          if (busy_left > 0) begin
            busy = 1'b1;
            busy_left--;
          end else if (!held && pkt_valid === 1'b1 && got_q.size() == 2) begin
            busy = 1'b1;
            busy_left = 1;
            held = 1;
          end
          if (busy) begin
            n_chk++;
            if (data_out !== exp_q[2] || pkt_valid !== 1'b1)
              $display("FAIL busy hold: got pv=%b d=%h want 1/%h",
                       pkt_valid, data_out, exp_q[2]);
            else n_pass++;
          end
        end
        if (!busy) begin
          if (pkt_valid === 1'b1) begin
            got_q.push_back(data_out);
          end else if (!par_seen && got_q.size() == len + 1) begin
            got_q.push_back(data_out);
            par_seen = 1;
            since = 0;
          end
        end
        @(negedge clock);
      end
    end
    pl_valid = 1'b0; busy = 1'b0; err = 1'b0;

    n_chk++;
    if (!fin) $display("FAIL done timeout: got no done want done pulse");
    else n_pass++;
    n_chk++;
    if (got_q.size() != exp_q.size())
      $display("FAIL byte count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_chk++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL byte %0d: got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    @(negedge clock);
    n_chk++;
    if (done !== 1'b0 || start_ready !== 1'b1)
      $display("FAIL after done: got done=%b sr=%b want 0/1", done, start_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_chk++;
    if (pkt_valid !== 1'b0 || data_out !== 8'h00 || done !== 1'b0 ||
        done_err !== 1'b0 || start_rej !== 1'b0 || pl_ready !== 1'b0)
      $display("FAIL reset values: got pv=%b d=%h dn=%b de=%b rj=%b pr=%b want 0",
               pkt_valid, data_out, done, done_err, start_rej, pl_ready);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_chk++;
    if (start_ready !== 1'b1)
      $display("FAIL start_ready after reset: got %b want 1", start_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    tx_pl = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd1, 3, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_busy_hold();
    tx_pl = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd1, 3, 2, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reject();
    logic [1:0] ra [2];
    logic [5:0] rl [2];
    ra[0] = 2'd3; rl[0] = 6'd5;
    ra[1] = 2'd1; rl[1] = 6'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      start_valid = 1'b1;
      start_addr  = ra[k];
      start_len   = rl[k];
      @(negedge clock);
      start_valid = 1'b0;
      n_chk++;
      if (start_rej !== 1'b1 || pkt_valid !== 1'b0 ||
          start_ready !== 1'b1 || pl_ready !== 1'b0)
        $display("FAIL reject %0d: got rj=%b pv=%b sr=%b pr=%b want 1/0/1/0",
                 k, start_rej, pkt_valid, start_ready, pl_ready);
      else n_pass++;
      @(negedge clock);
      n_chk++;
      if (start_rej !== 1'b0 || start_ready !== 1'b1)
        $display("FAIL reject pulse %0d: got rj=%b sr=%b want 0/1",
                 k, start_rej, start_ready);
      else n_pass++;
    end
  endtask

  task automatic test_max_len();
    tx_pl.delete();
    for (int i = 0; i < 63; i++) tx_pl.push_back(8'(i));
    run_pkt(2'd2, 63, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_err();
    tx_pl = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 8'h80};
    run_pkt(2'd0, 5, 0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    tx_pl = '{8'h44, 8'h55, 8'h66, 8'h77};
    run_pkt(2'd2, 4, 0, 1'b0, 1'b0, 2, 1'b0);
    tx_pl = '{8'h9C};
    run_pkt(2'd0, 1, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

`ifdef PARITY_INJECT_EN
  task automatic test_inject();
    tx_pl = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd1, 3, 0, 1'b0, 1'b1, 0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [1:0] a;
    int len;
    bit ue;
    bit inj;
    for (int k = 0; k < 8; k++) begin
      a   = 2'($urandom_range(2));
      len = int'($urandom_range(63, 1));
      ue  = 1'($urandom_range(1));
      inj = 1'b0;
`ifdef PARITY_INJECT_EN
      inj = 1'($urandom_range(1));
`endif
      tx_pl.delete();
      for (int i = 0; i < len; i++) tx_pl.push_back(8'($urandom));
      run_pkt(a, len, 1, ue, inj, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_hold();
    test_reject();
    test_max_len();
    test_err();
    test_mid_reset();
`ifdef PARITY_INJECT_EN
    test_inject();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
